gfx256_wbm_rr_arbiter: RTL and testbench
========================================

# gfx256_wbm_rr_arbiter

Registered, grant-locking round-robin arbiter that shares the single wbm read/write port among the four read masters (clip, fragment processor, blender, textblit) and the pixel writer. A grant is held for the whole transaction, from request until `ack_i`, and is released through a one-cycle gap, so the downstream Wishbone module always sees clean cycle boundaries. An optional write-priority mode with a starvation limit can be compiled in.

## Interface
Parameters:
- `WID`, 256, data bus width; `sel` width is `WID/8`.
- `WRITE_MAX`, 8, maximum consecutive writer grants while any read is pending. Used only when the write-priority mode is compiled in. Legal range 1..15.

Ports (N=0..3; index 0..3 = mN, index 4 = writer):
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `mN_read_request_i` in 1: read request. Held high until `mN_ack_o`.
- `mN_addr_i` in 32, `mN_sel_i` in WID/8: read address and byte selects.
- `mN_dat_o` out WID: equals `dat_i`.
- `mN_ack_o` out 1: `ack_i` gated by the mN grant.
- `mw_write_request_i` in 1, `mw_addr_i` in 32, `mw_sel_i` in WID/8, `mw_we_i` in 1, `mw_dat_i` in WID: writer request.
- `mw_ack_o` out 1: `ack_i` gated by the writer grant.
- `read_request_o` out 1: high while a read master holds the grant.
- `write_request_o` out 1: high while the writer holds the grant.
- `addr_o` out 32, `sel_o` out WID/8, `we_o` out 1, `dat_o` out WID: muxed from the grant holder. `dat_o` = `mw_dat_i` always.
- `dat_i` in WID, `ack_i` in 1: response from the wbm module.
- `master_busy_o` out 1: OR of all five request inputs (combinational).
- `grant_o` out 5: one-hot registered grant. All-zero when idle.

## Operation
The arbiter is a three-state FSM: IDLE, BUSY, GAP.

IDLE:
- If any request is high, the winner is chosen and `grant_o` is registered. Next state is BUSY.
- Winner selection is round-robin: search indices `last+1`, `last+2`, … modulo 5, where `last` is the index of the most recent grant. `last` resets to 4, so m0 wins first.

BUSY:
- Outputs are muxed from the grant holder; `read_request_o`/`write_request_o` follow the grant.
- On `ack_i`=1, the holder's ack is asserted that same cycle, `last` is set to the holder, the grant is cleared, and next state is GAP.
- If the holder drops its request with no ack (abort), the grant is cleared and next state is GAP. `last` is still updated.
- Requests from other masters never disturb the current grant.

GAP:
- One cycle with no grant. All request outputs are 0. Next state is IDLE.

Output rules:
- When there is no grant, `addr_o`=0, `sel_o`=0, `we_o`=0, and all `mN_ack_o`/`mw_ack_o`=0.
- `we_o` = `mw_we_i` only under the writer grant.
- `ack_i` arriving outside BUSY is ignored and routed to nobody.

Reset:
- Reset in any state, including mid-transaction, clears the state to IDLE, `grant_o` to 0, `last` to 4, and the write counter to 0.
- All registered outputs are 0 the cycle after `rst_i`.

## Timing
- Request-to-grant latency: 1 cycle. A request high at edge k gives grant and request outputs high after edge k+1.
- Ack path is combinational: `ack_i` → `mX_ack_o` in the same cycle.
- Minimum back-to-back period per transaction: IDLE → BUSY(ack) → GAP, which is 3 cycles with zero-wait `ack_i`.
- Simultaneous requests are resolved by the rotating pointer only. No master can be skipped for more than 4 grants.
- A master whose request stays high after its ack is re-arbitrated in IDLE like any other requester.

## Configuration
- `GFX256_ARB_WRITE_PRIO_EN` defined:
  - In IDLE, the writer wins whenever `mw_write_request_i`=1, unless `wcnt`=`WRITE_MAX`. In that case the round-robin winner among the read masters is granted instead.
  - `wcnt` is a 4-bit counter. It increments on each writer grant made while any read is pending, and clears on any read grant or when no read is pending.
  - Reads among themselves remain round-robin.
- Undefined: plain 5-way round-robin, the counter is absent, and `WRITE_MAX` is unused.

## Test plan
- Reset mid-BUSY: m2 granted, assert `rst_i` one cycle → next cycle `grant_o`=0, state IDLE, all outputs 0. Then m0 and m3 request together → m0 granted first.
- All five requesting continuously with zero-wait ack → grant order m0, m1, m2, m3, mw, m0…, one grant per 3 cycles, `we_o`=1 only on mw grants.
- m1 granted with `addr` 0x1000; m0 raises its request mid-BUSY; ack after 4 wait cycles → `addr_o` stays 0x1000 throughout, `m1_ack_o` pulses once, GAP, then m0 granted.
- Abort: m3 granted, drops its request with no ack → next cycle GAP with `read_request_o`=0, no ack issued. A stray `ack_i` in GAP reaches no master.
- With `GFX256_ARB_WRITE_PRIO_EN`, `WRITE_MAX`=2, writer and m0 requesting continuously → grants mw, mw, m0, mw, mw, m0.
- Without the macro, same stimulus → grants alternate m0, mw, m0, mw.

Source files
------------

// File: rtl/gfx256_wbm_rr_arbiter.sv
// rtl/gfx256_wbm_rr_arbiter.sv - grant-locking round-robin arbiter for the shared wbm port (optional GFX256_ARB_WRITE_PRIO_EN)
module gfx256_wbm_rr_arbiter #(
    parameter int WID       = 256,
    parameter int WRITE_MAX = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             m0_read_request_i,
    input  logic [31:0]      m0_addr_i,
    input  logic [WID/8-1:0] m0_sel_i,
    output logic [WID-1:0]   m0_dat_o,
    output logic             m0_ack_o,
    input  logic             m1_read_request_i,
    input  logic [31:0]      m1_addr_i,
    input  logic [WID/8-1:0] m1_sel_i,
    output logic [WID-1:0]   m1_dat_o,
    output logic             m1_ack_o,
    input  logic             m2_read_request_i,
    input  logic [31:0]      m2_addr_i,
    input  logic [WID/8-1:0] m2_sel_i,
    output logic [WID-1:0]   m2_dat_o,
    output logic             m2_ack_o,
    input  logic             m3_read_request_i,
    input  logic [31:0]      m3_addr_i,
    input  logic [WID/8-1:0] m3_sel_i,
    output logic [WID-1:0]   m3_dat_o,
    output logic             m3_ack_o,
    input  logic             mw_write_request_i,
    input  logic [31:0]      mw_addr_i,
    input  logic [WID/8-1:0] mw_sel_i,
    input  logic             mw_we_i,
    input  logic [WID-1:0]   mw_dat_i,
    output logic             mw_ack_o,
    output logic             read_request_o,
    output logic             write_request_o,
    output logic [31:0]      addr_o,
    output logic [WID/8-1:0] sel_o,
    output logic             we_o,
    output logic [WID-1:0]   dat_o,
    input  logic [WID-1:0]   dat_i,
    input  logic             ack_i,
    output logic             master_busy_o,
    output logic [4:0]       grant_o
);

    if (WRITE_MAX < 1 || WRITE_MAX > 15) begin : g_write_max_check
        $error("WRITE_MAX out of range 1..15");
    end

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t     state, state_n;
    logic [4:0] grant, grant_n;
    logic [2:0] gidx, gidx_n;
    logic [2:0] last, last_n;
    logic [4:0] req;
    logic [3:0] pick;
    logic [2:0] win;

    assign req = {mw_write_request_i, m3_read_request_i, m2_read_request_i,
                  m1_read_request_i, m0_read_request_i};

    // Returns {found, index} of the first requester after l, wrapping modulo 5.
    function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] l);
        logic [3:0] res;
        logic [3:0] c;
        res = 4'b0;
        for (int i = 5; i >= 1; i--) begin
            c = {1'b0, l} + 4'(i);
            if (c >= 4'd5) c = c - 4'd5;
            if (r[c[2:0]]) res = {1'b1, c[2:0]};
        end
        return res;
    endfunction

`ifdef GFX256_ARB_WRITE_PRIO_EN
    localparam logic [3:0] WMAX = 4'(WRITE_MAX);
    logic [3:0] wcnt, wcnt_n;
    // Separate read pointer so reads keep rotating even though the writer keeps taking the slot.
    logic [2:0] last_rd, last_rd_n;
    logic [3:0] rd_pick;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            grant <= 5'b0;
            gidx  <= 3'd0;
            last  <= 3'd4;
`ifdef GFX256_ARB_WRITE_PRIO_EN
            wcnt    <= 4'd0;
            last_rd <= 3'd4;
`endif
        end else begin
            state <= state_n;
            grant <= grant_n;
            gidx  <= gidx_n;
            last  <= last_n;
`ifdef GFX256_ARB_WRITE_PRIO_EN
            wcnt    <= wcnt_n;
            last_rd <= last_rd_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        gidx_n  = gidx;
        last_n  = last;
        pick    = rr_pick(req, last);
        win     = pick[2:0];
`ifdef GFX256_ARB_WRITE_PRIO_EN
        last_rd_n = last_rd;
        wcnt_n    = (|req[3:0]) ? wcnt : 4'd0;
        rd_pick   = rr_pick({1'b0, req[3:0]}, last_rd);
        if (req[4] && (wcnt != WMAX || !rd_pick[3]))
            win = 3'd4;
        else
            win = rd_pick[2:0];
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_n = 5'b00001 << win;
                    gidx_n  = win;
                    state_n = BUSY;
`ifdef GFX256_ARB_WRITE_PRIO_EN
                    if (win == 3'd4) begin
                        if (|req[3:0]) wcnt_n = wcnt + 4'd1;
                    end else begin
                        wcnt_n = 4'd0;
                    end
`endif
                end
            end
            BUSY: begin
                // Release on ack, or on abort when the holder drops its request.
                if (ack_i || !(|(req & grant))) begin
                    grant_n = 5'b0;
                    last_n  = gidx;
                    state_n = GAP;
`ifdef GFX256_ARB_WRITE_PRIO_EN
                    if (gidx != 3'd4) last_rd_n = gidx;
`endif
                end
            end
            GAP: state_n = IDLE;
            default: begin
                state_n = IDLE;
                grant_n = 5'b0;
            end
        endcase
    end

    always_comb begin
        addr_o = 32'h0;
        sel_o  = '0;
        we_o   = 1'b0;
        case (grant)
            5'b00001: begin addr_o = m0_addr_i; sel_o = m0_sel_i; end
            5'b00010: begin addr_o = m1_addr_i; sel_o = m1_sel_i; end
            5'b00100: begin addr_o = m2_addr_i; sel_o = m2_sel_i; end
            5'b01000: begin addr_o = m3_addr_i; sel_o = m3_sel_i; end
            5'b10000: begin addr_o = mw_addr_i; sel_o = mw_sel_i; we_o = mw_we_i; end
            default: ;
        endcase
    end

    // Grant is only non-zero in BUSY, so ack_i in IDLE/GAP reaches nobody.
    assign m0_ack_o = ack_i & grant[0];
    assign m1_ack_o = ack_i & grant[1];
    assign m2_ack_o = ack_i & grant[2];
    assign m3_ack_o = ack_i & grant[3];
    assign mw_ack_o = ack_i & grant[4];

    assign m0_dat_o        = dat_i;
    assign m1_dat_o        = dat_i;
    assign m2_dat_o        = dat_i;
    assign m3_dat_o        = dat_i;
    assign dat_o           = mw_dat_i;
    assign read_request_o  = |grant[3:0];
    assign write_request_o = grant[4];
    assign master_busy_o   = |req;
    assign grant_o         = grant;

endmodule

// File: tb/tb_gfx256_wbm_rr_arbiter.sv
// tb/tb_gfx256_wbm_rr_arbiter.sv - directed table-driven bench for gfx256_wbm_rr_arbiter
module tb_gfx256_wbm_rr_arbiter;
    localparam int WID = 256;
    localparam int SW  = WID / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] req_tb = 5'b0;
    logic ack_tb = 1'b0;
    logic we_tb = 1'b1;

    logic [31:0] a0 = 32'h0000_0800, a1 = 32'h0000_1000, a2 = 32'h0000_2000;
    logic [31:0] a3 = 32'h0000_3000, aw = 32'h0000_4000;
    logic [SW-1:0] s0 = 32'h0000_0001, s1 = 32'h0000_0002, s2 = 32'h0000_0004;
    logic [SW-1:0] s3 = 32'h0000_0008, sw = 32'hFFFF_0000;
    logic [WID-1:0] wdat = {8{32'hCAFE_0123}};
    logic [WID-1:0] rdat = {8{32'h5A5A_C3C3}};

    logic [WID-1:0] d0, d1, d2, d3, dout;
    logic k0, k1, k2, k3, kw;
    logic rreq, wreq, we_out, busy;
    logic [31:0] addr_out;
    logic [SW-1:0] sel_out;
    logic [4:0] grant;

    gfx256_wbm_rr_arbiter #(.WID(WID), .WRITE_MAX(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_read_request_i(req_tb[0]), .m0_addr_i(a0), .m0_sel_i(s0), .m0_dat_o(d0), .m0_ack_o(k0),
        .m1_read_request_i(req_tb[1]), .m1_addr_i(a1), .m1_sel_i(s1), .m1_dat_o(d1), .m1_ack_o(k1),
        .m2_read_request_i(req_tb[2]), .m2_addr_i(a2), .m2_sel_i(s2), .m2_dat_o(d2), .m2_ack_o(k2),
        .m3_read_request_i(req_tb[3]), .m3_addr_i(a3), .m3_sel_i(s3), .m3_dat_o(d3), .m3_ack_o(k3),
        .mw_write_request_i(req_tb[4]), .mw_addr_i(aw), .mw_sel_i(sw), .mw_we_i(we_tb),
        .mw_dat_i(wdat), .mw_ack_o(kw),
        .read_request_o(rreq), .write_request_o(wreq), .addr_o(addr_out), .sel_o(sel_out),
        .we_o(we_out), .dat_o(dout), .dat_i(rdat), .ack_i(ack_tb),
        .master_busy_o(busy), .grant_o(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] req;
        logic       ack;
        logic [4:0] g;
        logic [4:0] k;
    } vec_t;

    vec_t vt[$];
    int checks = 0;
    int errors = 0;

`ifdef GFX256_ARB_WRITE_PRIO_EN
    logic [4:0] rot [6] = '{5'h10, 5'h10, 5'h01, 5'h10, 5'h10, 5'h02};
    logic [4:0] cap_exp [6] = '{5'h10, 5'h10, 5'h01, 5'h10, 5'h10, 5'h01};
`else
    logic [4:0] rot [6] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01};
    logic [4:0] cap_exp [6] = '{5'h01, 5'h10, 5'h01, 5'h10, 5'h01, 5'h10};
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] r, input logic a, input logic [4:0] g, input logic [4:0] k);
        vt.push_back('{req: r, ack: a, g: g, k: k});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addr_of(input logic [4:0] g);
        case (g)
            5'h01: return a0;
            5'h02: return a1;
            5'h04: return a2;
            5'h08: return a3;
            5'h10: return aw;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [SW-1:0] sel_of(input logic [4:0] g);
        case (g)
            5'h01: return s0;
            5'h02: return s1;
            5'h04: return s2;
            5'h08: return s3;
            5'h10: return sw;
            default: return '0;
        endcase
    endfunction

    initial begin
        logic [4:0] got [6];
        int n;

        add(5'h00, 1'b0, 5'h00, 5'h00);
        add(5'h1f, 1'b1, 5'h00, 5'h00);
        for (int j = 0; j < 6; j++) begin
            add(5'h1f, 1'b1, rot[j], rot[j]);
            if (j < 5) begin
                add(5'h1f, 1'b1, 5'h00, 5'h00);
                add(5'h1f, 1'b1, 5'h00, 5'h00);
            end
        end
        add(5'h00, 1'b0, 5'h00, 5'h00);
        add(5'h00, 1'b0, 5'h00, 5'h00);
        // m3 abort, then a stray ack in GAP
        add(5'h08, 1'b0, 5'h00, 5'h00);
        add(5'h08, 1'b0, 5'h08, 5'h00);
        add(5'h00, 1'b0, 5'h08, 5'h00);
        add(5'h00, 1'b1, 5'h00, 5'h00);
        add(5'h00, 1'b0, 5'h00, 5'h00);
        // m1 held across wait states while m0 queues behind it
        add(5'h02, 1'b0, 5'h00, 5'h00);
        for (int j = 0; j < 4; j++) add(5'h03, 1'b0, 5'h02, 5'h00);
        add(5'h03, 1'b1, 5'h02, 5'h02);
        add(5'h01, 1'b0, 5'h00, 5'h00);
        add(5'h01, 1'b0, 5'h00, 5'h00);
        add(5'h01, 1'b1, 5'h01, 5'h01);
        add(5'h00, 1'b0, 5'h00, 5'h00);

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            req_tb = vt[i].req;
            ack_tb = vt[i].ack;
            #3;
            chk($sformatf("grant[%0d]", i), 64'(grant), 64'(vt[i].g));
            chk($sformatf("acks[%0d]", i), 64'({kw, k3, k2, k1, k0}), 64'(vt[i].k));
            chk($sformatf("rwreq[%0d]", i), 64'({wreq, rreq}), 64'({vt[i].g[4], |vt[i].g[3:0]}));
            chk($sformatf("addr[%0d]", i), 64'(addr_out), 64'(addr_of(vt[i].g)));
            chk($sformatf("sel[%0d]", i), 64'(sel_out), 64'(sel_of(vt[i].g)));
            chk($sformatf("we[%0d]", i), 64'(we_out), 64'(vt[i].g[4]));
            chk($sformatf("busy[%0d]", i), 64'(busy), 64'(|vt[i].req));
            tick();
        end

        chk("m2_dat", d2[63:0], rdat[63:0]);
        chk("dat_o", dout[63:0], wdat[63:0]);

        // Reset mid-BUSY must also restore the pointer so m0 beats m3.
        ack_tb = 1'b0;
        req_tb = 5'h04;
        tick();
        #3;
        chk("rst_pre_grant", 64'(grant), 64'h04);
        chk("rst_pre_addr", 64'(addr_out), 64'(a2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_tb = 5'h09;
        ack_tb = 1'b1;
        #3;
        chk("rst_grant", 64'(grant), 64'h00);
        chk("rst_outs", 64'({rreq, wreq, we_out, kw, k3, k2, k1, k0}), 64'h0);
        chk("rst_addr", 64'(addr_out), 64'h0);
        chk("rst_sel", 64'(sel_out), 64'h0);
        ack_tb = 1'b0;
        tick();
        #3;
        chk("rst_first", 64'(grant), 64'h01);

        // Writer and m0 competing continuously with zero-wait ack.
        rst = 1'b1;
        req_tb = 5'h00;
        tick();
        rst = 1'b0;
        we_tb = 1'b0;
        req_tb = 5'h11;
        ack_tb = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            #3;
            if (grant != 5'h00) begin
                got[n] = grant;
                n++;
                chk("cap_we", 64'(we_out), 64'h0);
            end
            tick();
        end
        chk("cap_count", 64'(n), 64'd6);
        for (int j = 0; j < n; j++)
            chk($sformatf("cap[%0d]", j), 64'(got[j]), 64'(cap_exp[j]));

        req_tb = 5'h00;
        ack_tb = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
